// File: rtl/ifetch.sv
// Instruction fetch unit: drives the Yduck instruction bus (one-cycle read latency)
// and presents a valid, PC-tagged instruction stream to decode with stall and jump.
module ifetch #(
  parameter int              DW     = 16,
  parameter int              AW     = 16,
  parameter logic [AW-1:0]   RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] ibus_addr,
  input  logic [DW-1:0] ibus_dout,
  input  logic          stall,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_vld
);

  logic [AW-1:0] pc;
  logic [AW-1:0] inst_pc_q;
  logic          vld_q;
  logic          hold_q;
  logic [DW-1:0] buf_q;

  // Jump beats stall beats advance. A stall captures the word currently on
  // ibus_dout once, because the bus keeps re-reading pc and would overwrite it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RST_PC;
      inst_pc_q <= '0;
      vld_q     <= 1'b0;
      hold_q    <= 1'b0;
      buf_q     <= '0;
    end else if (jmp_en) begin
      pc     <= jmp_addr;
      vld_q  <= 1'b0;
      hold_q <= 1'b0;
    end else if (stall) begin
      if (vld_q && !hold_q) begin
        buf_q  <= ibus_dout;
        hold_q <= 1'b1;
      end
    end else begin
      inst_pc_q <= pc;
      pc        <= pc + {{(AW-1){1'b0}}, 1'b1};
      vld_q     <= 1'b1;
      hold_q    <= 1'b0;
    end
  end

  assign ibus_addr = pc;
  assign inst_vld  = vld_q;
  assign inst_pc   = inst_pc_q;
  assign inst      = !vld_q ? '0 : (hold_q ? buf_q : ibus_dout);

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: behavioural sync-read instruction memory, directed vector
// table, async-reset sequence and randomized stimulus against a stream model.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ibus_addr;
  logic [15:0] ibus_dout = 16'h0000;
  logic        stall = 1'b0;
  logic        jmp_en = 1'b0;
  logic [15:0] jmp_addr = 16'h0000;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_vld;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [128];

  // Model: next address to issue, and the (pc, valid) currently shown to decode.
  // While valid, the shown word is simply mem at the shown pc.
  logic [15:0] m_issue;
  logic [15:0] m_pc;
  logic        m_vld;

  ifetch #(.DW(16), .AW(16), .RST_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .ibus_addr (ibus_addr),
    .ibus_dout (ibus_dout),
    .stall     (stall),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_vld  (inst_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ibus_dout <= mem[ibus_addr[6:0]];

  typedef struct {
    logic        s;
    logic        j;
    logic [15:0] ja;
    logic        e_vld;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs [26];

  task automatic check(input string name, input logic e_vld, input logic [15:0] e_inst,
                       input logic [15:0] e_pc, input logic [15:0] e_addr);
    checks++;
    if (inst_vld !== e_vld || inst !== e_inst || inst_pc !== e_pc || ibus_addr !== e_addr) begin
      errors++;
      $display("FAIL %s: got vld=%0b inst=%h pc=%h addr=%h, want vld=%0b inst=%h pc=%h addr=%h",
               name, inst_vld, inst, inst_pc, ibus_addr, e_vld, e_inst, e_pc, e_addr);
    end else begin
      $display("ok   %s: vld=%0b inst=%h pc=%h addr=%h", name, inst_vld, inst, inst_pc, ibus_addr);
    end
  endtask

  task automatic model_reset();
    m_issue = 16'h0000;
    m_pc    = 16'h0000;
    m_vld   = 1'b0;
  endtask

  function automatic logic [15:0] model_inst();
    return m_vld ? mem[m_pc[6:0]] : 16'h0000;
  endfunction

  // Apply inputs for one posedge, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic s, input logic j, input logic [15:0] ja);
    stall    = s;
    jmp_en   = j;
    jmp_addr = ja;
    @(posedge clk);
    #1;
    if (j) begin
      m_issue = ja;
      m_vld   = 1'b0;
    end else if (!s) begin
      m_pc    = m_issue;
      m_issue = m_issue + 16'h0001;
      m_vld   = 1'b1;
    end
    stall    = 1'b0;
    jmp_en   = 1'b0;
    jmp_addr = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hC000 | 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[7'h20] = 16'hABCD; mem[7'h7F] = 16'h7F7F;

    //          s  j  ja        vld inst      pc        addr
    vecs[0]  = '{0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0001};
    vecs[1]  = '{0, 0, 16'h0000, 1, 16'h2222, 16'h0001, 16'h0002};
    vecs[2]  = '{1, 0, 16'h0000, 1, 16'h2222, 16'h0001, 16'h0002};
    vecs[3]  = '{1, 0, 16'h0000, 1, 16'h2222, 16'h0001, 16'h0002};
    vecs[4]  = '{1, 0, 16'h0000, 1, 16'h2222, 16'h0001, 16'h0002};
    vecs[5]  = '{0, 0, 16'h0000, 1, 16'h3333, 16'h0002, 16'h0003};
    vecs[6]  = '{0, 0, 16'h0000, 1, 16'h4444, 16'h0003, 16'h0004};
    vecs[7]  = '{0, 1, 16'h0000, 0, 16'h0000, 16'h0003, 16'h0000};
    vecs[8]  = '{0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0001};
    vecs[9]  = '{0, 1, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0020};
    vecs[10] = '{0, 0, 16'h0000, 1, 16'hABCD, 16'h0020, 16'h0021};
    vecs[11] = '{0, 0, 16'h0000, 1, 16'hC021, 16'h0021, 16'h0022};
    vecs[12] = '{0, 1, 16'h0000, 0, 16'h0000, 16'h0021, 16'h0000};
    vecs[13] = '{0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0001};
    vecs[14] = '{0, 0, 16'h0000, 1, 16'h2222, 16'h0001, 16'h0002};
    vecs[15] = '{0, 0, 16'h0000, 1, 16'h3333, 16'h0002, 16'h0003};
    vecs[16] = '{1, 0, 16'h0000, 1, 16'h3333, 16'h0002, 16'h0003};
    vecs[17] = '{1, 1, 16'h0000, 0, 16'h0000, 16'h0002, 16'h0000};
    vecs[18] = '{0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0001};
    vecs[19] = '{0, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[20] = '{0, 0, 16'h0000, 1, 16'h7F7F, 16'hFFFF, 16'h0000};
    vecs[21] = '{0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 16'h0001};
    vecs[22] = '{0, 0, 16'h0000, 1, 16'h2222, 16'h0001, 16'h0002};
    vecs[23] = '{0, 1, 16'h0020, 0, 16'h0000, 16'h0001, 16'h0020};
    vecs[24] = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0001, 16'h0020};
    vecs[25] = '{0, 0, 16'h0000, 1, 16'hABCD, 16'h0020, 16'h0021};

    // Reset held across clock edges
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("in_reset", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].s, vecs[i].j, vecs[i].ja);
      check($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_addr);
    end

    // Reset asserted between edges mid-stream takes effect at once
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 16'h0000); check("restart0", 1'b1, 16'h1111, 16'h0000, 16'h0001);
    step(0, 0, 16'h0000); check("restart1", 1'b1, 16'h2222, 16'h0001, 16'h0002);
    step(0, 0, 16'h0000); check("restart2", 1'b1, 16'h3333, 16'h0002, 16'h0003);
    step(0, 0, 16'h0000); check("restart3", 1'b1, 16'h4444, 16'h0003, 16'h0004);

    // Randomized stream against the model
    for (int n = 0; n < 400; n++) begin
      logic        rs;
      logic        rj;
      logic [15:0] ra;
      rs = ($urandom_range(0, 9) < 3);
      rj = ($urandom_range(0, 9) == 0);
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      step(rs, rj, ra);
      check($sformatf("rand%0d s=%0b j=%0b", n, rs, rj), m_vld, model_inst(), m_pc, m_issue);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
